mem_sum_sweep: RTL and testbench

Autonomous sweep engine for the input/output memory bank pair of the sequential memory lab. On a single start pulse, it reads a contiguous address range of the input bank and writes the sum of each word's two byte halves into the same address of the output bank, one word per clock. It replaces the hold-two-buttons manual write path. It sits between the debounced-button control logic and the two `memory` instances, and drives their address, enable and data lines.

---
 rtl/mem_sum_sweep.sv | 129 ++++++++++++
 tb/tb_mem_sum_sweep.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_sum_sweep.sv
// Sweep engine: reads in-bank words first_addr..last_addr and writes the sum of
// each word's byte halves to the same out-bank address, one word per clock.
module mem_sum_sweep #(
  parameter int AW = 4,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic [AW-1:0] in_addr,
  output logic          in_oe,
  input  logic [DW-1:0] in_rdata,
  output logic [AW-1:0] out_addr,
  output logic          out_we,
  output logic [DW-1:0] out_wdata,
  output logic          busy,
  output logic          done,
  output logic          range_err,
  output logic [AW:0]   carry_cnt,
  output logic [1:0]    dbg_state
);

  localparam int HW = DW / 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_last;
  logic [AW-1:0] r_in_addr;
  logic [AW-1:0] r_out_addr;
  logic          r_in_oe;
  logic          r_out_we;
  logic          r_busy;
  logic          r_done;
  logic          r_range_err;
  logic [AW:0]   r_carry;
  logic [HW:0]   w_sum;

  assign w_sum = {1'b0, in_rdata[DW-1:HW]} + {1'b0, in_rdata[HW-1:0]};

  // Data is zero whenever no write is issued, so a tristate wrapper can key on out_we.
  assign out_wdata = r_out_we ? DW'(w_sum) : '0;

  assign in_addr   = r_in_addr;
  assign in_oe     = r_in_oe;
  assign out_addr  = r_out_addr;
  assign out_we    = r_out_we;
  assign busy      = r_busy;
  assign done      = r_done;
  assign range_err = r_range_err;
  assign carry_cnt = r_carry;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= '0;
      r_in_addr   <= '0;
      r_out_addr  <= '0;
      r_in_oe     <= 1'b0;
      r_out_we    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
      r_carry     <= '0;
    end else begin
      r_done      <= 1'b0;
      r_range_err <= 1'b0;
      r_out_addr  <= r_in_addr;
      // A write present on this edge always lands, even if abort is high now.
      if (r_out_we && w_sum[HW]) r_carry <= r_carry + (AW+1)'(1);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (last_addr >= first_addr) begin
              r_last    <= last_addr;
              r_in_addr <= first_addr;
              r_in_oe   <= 1'b1;
              r_busy    <= 1'b1;
              r_carry   <= '0;
              r_state   <= S_RUN;
            end else begin
              r_range_err <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_in_oe  <= 1'b0;
            r_out_we <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_out_we <= 1'b1;
            // Stop on last_addr rather than incrementing, so the top address never wraps.
            if (r_in_addr == r_last) begin
              r_in_oe <= 1'b0;
              r_state <= S_DRAIN;
            end else begin
              r_in_addr <= r_in_addr + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          r_out_we <= 1'b0;
          r_busy   <= 1'b0;
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sum_sweep.sv
// Bench for mem_sum_sweep: behavioural input bank, cycle-by-cycle expectations
// derived from the sweep timing rules, plus directed and random ranges.
module tb_mem_sum_sweep;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  first_addr = '0;
  logic [3:0]  last_addr = '0;
  logic [3:0]  in_addr;
  logic        in_oe;
  logic [15:0] in_rdata;
  logic [3:0]  out_addr;
  logic        out_we;
  logic [15:0] out_wdata;
  logic        busy;
  logic        done;
  logic        range_err;
  logic [4:0]  carry_cnt;
  logic [1:0]  dbg_state;

  logic [15:0] mem_in [16];
  int          n_checks = 0;
  int          n_fail = 0;

  mem_sum_sweep #(.AW(4), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_addr(first_addr), .last_addr(last_addr),
    .in_addr(in_addr), .in_oe(in_oe), .in_rdata(in_rdata),
    .out_addr(out_addr), .out_we(out_we), .out_wdata(out_wdata),
    .busy(busy), .done(done), .range_err(range_err),
    .carry_cnt(carry_cnt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Input bank: synchronous read, data valid the clock after in_oe.
  always @(posedge clk) begin
    if (in_oe) in_rdata <= mem_in[in_addr];
  end

  function automatic int ref_sum(input logic [15:0] w);
    return int'(w[15:8]) + int'(w[7:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " in_oe"},     32'(in_oe),     32'd0);
    chk({tag, " out_we"},    32'(out_we),    32'd0);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " done"},      32'(done),      32'd0);
    chk({tag, " range_err"}, 32'(range_err), 32'd0);
    chk({tag, " carry_cnt"}, 32'(carry_cnt), 32'd0);
    chk({tag, " in_addr"},   32'(in_addr),   32'd0);
    chk({tag, " out_addr"},  32'(out_addr),  32'd0);
    chk({tag, " out_wdata"}, 32'(out_wdata), 32'd0);
  endtask

  // Runs one sweep f..l; caller is #1 past an edge. abort_cyc=0 means no abort.
  // Returns in the last checked cycle so a following start lands in that cycle.
  task automatic sweep(input int f, input int l, input int abort_cyc, input logic abort_with_start);
    int n, a, lim, exp_carry, s;
    logic e_oe, e_we, e_busy, e_done;
    n = l - f + 1;
    a = (abort_cyc == 0) ? 1000 : abort_cyc;
    lim = (abort_cyc == 0) ? n + 3 : a + 1;
    exp_carry = 0;
    first_addr = 4'(f);
    last_addr = 4'(l);
    start = 1'b1;
    abort = abort_with_start;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= lim; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
        abort = 1'b0;
      end
      if (c == a) abort = 1'b1;
      e_oe   = (c <= n) && (c <= a);
      e_we   = (c >= 2) && (c <= n + 1) && (c <= a);
      e_busy = (c <= n + 1) && (c <= a);
      e_done = (a > n + 2) && (c == n + 2);
      chk($sformatf("in_oe %0d..%0d c%0d", f, l, c),     32'(in_oe),     32'(e_oe));
      chk($sformatf("out_we %0d..%0d c%0d", f, l, c),    32'(out_we),    32'(e_we));
      chk($sformatf("busy %0d..%0d c%0d", f, l, c),      32'(busy),      32'(e_busy));
      chk($sformatf("done %0d..%0d c%0d", f, l, c),      32'(done),      32'(e_done));
      chk($sformatf("range_err %0d..%0d c%0d", f, l, c), 32'(range_err), 32'd0);
      if (e_oe)
        chk($sformatf("in_addr %0d..%0d c%0d", f, l, c), 32'(in_addr), 32'(f + c - 1));
      if (e_we) begin
        s = ref_sum(mem_in[f + c - 2]);
        if (s > 255) exp_carry++;
        chk($sformatf("out_addr %0d..%0d c%0d", f, l, c),  32'(out_addr),  32'(f + c - 2));
        chk($sformatf("out_wdata %0d..%0d c%0d", f, l, c), 32'(out_wdata), 32'(s));
      end else begin
        chk($sformatf("out_wdata idle %0d..%0d c%0d", f, l, c), 32'(out_wdata), 32'd0);
      end
    end
    chk($sformatf("carry_cnt %0d..%0d", f, l), 32'(carry_cnt), 32'(exp_carry));
  endtask

  initial begin
    int f, l;
    for (int i = 0; i < 16; i++) mem_in[i] = {4'h0, 4'(i), 8'hF0};

    // Reset state
    #3;
    chk_all_zero("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full sweep 0..15 with {i, F0} words: sums i+F0, no carries, done in cycle 18
    sweep(0, 15, 0, 1'b0);

    // Carry count over 4..7 (start together with abort: start wins)
    mem_in[4] = 16'hFFFF;
    mem_in[5] = 16'h8080;
    mem_in[6] = 16'h7F80;
    mem_in[7] = 16'h0101;
    sweep(4, 7, 0, 1'b1);
    chk("carry_test_cnt", 32'(carry_cnt), 32'd2);

    // Range error: 9..3 rejected
    first_addr = 4'd9;
    last_addr = 4'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("rerr range_err c%0d", c), 32'(range_err), 32'(c == 1));
      chk($sformatf("rerr in_oe c%0d", c),     32'(in_oe),     32'd0);
      chk($sformatf("rerr out_we c%0d", c),    32'(out_we),    32'd0);
      chk($sformatf("rerr busy c%0d", c),      32'(busy),      32'd0);
    end

    // Single word at the top address
    for (int i = 0; i < 16; i++) mem_in[i] = 16'($urandom);
    sweep(15, 15, 0, 1'b0);

    // Abort in cycle 6 of 0..15, then a start in cycle 7 runs normally
    for (int i = 0; i < 16; i++) mem_in[i] = {4'h0, 4'(i), 8'hF0};
    sweep(0, 15, 6, 1'b0);
    sweep(2, 9, 0, 1'b0);

    // Async reset mid-sweep, between edges in cycle 5
    first_addr = 4'd0;
    last_addr = 4'd15;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    sweep(2, 3, 0, 1'b0);

    // Random contents and ranges, one with a random abort
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) mem_in[i] = 16'($urandom);
      f = $urandom_range(0, 15);
      l = $urandom_range(f, 15);
      if (it == 5 && l - f >= 2)
        sweep(f, l, $urandom_range(2, l - f + 1), 1'b0);
      else
        sweep(f, l, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
